// File: rtl/sort4_stream_ctrl.sv
// sort4_stream_ctrl: valid/ready front end for a fixed-latency 4-word sorter, credit-gated output FIFO.
// Define SORT4_STREAM_CTRL_STATS_EN to add the stat_groups/stat_stall counters.
module sort4_stream_ctrl #(
  parameter int DW       = 8,
  parameter int SORT_LAT = 2,
  parameter int DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*DW-1:0] in_data,
  output logic [4*DW-1:0] sort_inp,
  input  logic [4*DW-1:0] sort_outp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*DW-1:0] out_data,
  output logic            busy
`ifdef SORT4_STREAM_CTRL_STATS_EN
  ,
  output logic [31:0]     stat_groups,
  output logic [31:0]     stat_stall
`endif
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CW   = $clog2(DEPTH + SORT_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [SORT_LAT-1:0] vld_q, vld_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [4*DW-1:0]     mem_q [DEPTH];
  logic [4*DW-1:0]     mem_d [DEPTH];
  logic [CW-1:0]       inflight;
  logic                accept, push, pop;

  // Credits count both buffered and in-flight groups so every sorter result has a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SORT_LAT; i++) inflight = inflight + CW'(vld_q[i]);
    busy      = (inflight != '0) || (count_q != '0);
    in_ready  = (state_q == RUN) && (CW'(count_q) + inflight < CW'(DEPTH));
    accept    = in_valid && in_ready;
    push      = vld_q[SORT_LAT-1];
    out_valid = count_q != '0;
    pop       = out_valid && out_ready;
    sort_inp  = in_data;
    out_data  = out_valid ? mem_q[rd_q] : '0;
    state_d   = en ? RUN : busy ? DRAIN : IDLE;
    vld_d     = SORT_LAT'({vld_q, accept});
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    count_d   = count_q + CNTW'(push) - CNTW'(pop);
    mem_d     = mem_q;
    if (push) mem_d[wr_q] = sort_outp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vld_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

`ifdef SORT4_STREAM_CTRL_STATS_EN
  logic [31:0] stat_groups_q, stat_groups_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_groups_d = stat_groups_q + 32'(accept);
    stat_stall_d  = stat_stall_q + 32'(in_valid && !in_ready && state_q == RUN);
    stat_groups   = stat_groups_q;
    stat_stall    = stat_stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_groups_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_groups_q <= stat_groups_d;
      stat_stall_q  <= stat_stall_d;
    end
  end
`endif
endmodule

// File: tb/tb_sort4_stream_ctrl.sv
// tb_sort4_stream_ctrl: directed bench with a 2-stage behavioural sorter and an in-order scoreboard.
module tb_sort4_stream_ctrl;
  logic        clk = 0, rst = 1, en = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0, sort_inp, sort_outp, out_data;
  logic        in_ready, out_valid, busy;
  logic [31:0] s1 = 0, s2 = 0;
  logic [31:0] exp_q [$];
  int n_tests = 0, n_fail = 0, n_acc = 0, n_out = 0, outstanding = 0, max_out = 0;

  always #5 clk = ~clk;

  sort4_stream_ctrl #(.DW(8), .SORT_LAT(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sort_inp(sort_inp), .sort_outp(sort_outp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  function automatic logic [31:0] sort4(input logic [31:0] x);
    logic [7:0] w [4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) w[i] = x[8*i +: 8];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (w[j] > w[j+1]) begin t = w[j]; w[j] = w[j+1]; w[j+1] = t; end
    return {w[3], w[2], w[1], w[0]};
  endfunction

  always @(posedge clk) begin
    s1 <= sort4(sort_inp);
    s2 <= s1;
  end
  assign sort_outp = s2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes seen at the negedge are exactly those taken at the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(sort4(in_data));
        n_acc++;
        outstanding++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        outstanding--;
        if (exp_q.size() == 0) check("sb_nonempty", 32'(exp_q.size()), 1);
        else check("sb_order", out_data, exp_q.pop_front());
      end
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  task automatic send_expect(input logic [31:0] d, input logic [31:0] e, input string tag);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check({tag, "_rdy"}, in_ready, 1);
    in_valid = 1;
    in_data  = d;
    tick();
    in_valid = 0;
    check({tag, "_lat1"}, out_valid, 0);
    tick();
    check({tag, "_lat2"}, out_valid, 0);
    tick();
    check({tag, "_lat3"}, out_valid, 1);
    check({tag, "_data"}, out_data, e);
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 30 && busy; i++) tick();
    check(tag, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, o0, stalls;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    tick();
    rst = 0;
    en  = 1;
    tick();

    send_expect(32'h01090305, 32'h09050301, "basic");
    check("basic_busy_after_pop", busy, 0);
    check("basic_empty_after_pop", out_valid, 0);

    send_expect(32'hFF00FF00, 32'hFFFF0000, "dup");
    send_expect(32'h7F7F7F7F, 32'h7F7F7F7F, "same");

    out_ready = 1;
    o0 = n_out;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1;
      in_data  = $urandom;
      if (!in_ready) stalls++;
      tick();
    end
    in_valid = 0;
    check("tput_stalls", stalls, 0);
    wait_idle("tput_idle");
    check("tput_outputs", n_out - o0, 16);
    check("tput_sb_empty", exp_q.size(), 0);

    out_ready = 0;
    a0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      in_data  = $urandom;
      tick();
    end
    check("bp_accepted", n_acc - a0, 4);
    check("bp_in_ready_low", in_ready, 0);
    in_valid  = 0;
    o0        = n_out;
    out_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    check("bp_outputs", n_out - o0, 4);
    check("bp_in_ready_back", in_ready, 1);

    out_ready = 0;
    a0 = n_acc;
    o0 = n_out;
    in_valid = 1;
    in_data  = 32'h11223344;
    tick();
    in_data  = 32'hA0B0C0D0;
    tick();
    in_valid = 0;
    en = 0;
    tick();
    check("drain_in_ready", in_ready, 0);
    check("drain_busy", busy, 1);
    in_valid  = 1;
    in_data   = 32'h55555555;
    out_ready = 1;
    wait_idle("drain_idle");
    tick();
    in_valid = 0;
    check("drain_accepted", n_acc - a0, 2);
    check("drain_outputs", n_out - o0, 2);
    check("idle_in_ready", in_ready, 0);
    out_ready = 0;
    en = 1;
    tick();
    check("rerun_in_ready", in_ready, 1);

    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom;
      tick();
    end
    in_valid = 0;
    check("prerst_busy", busy, 1);
    check("prerst_out_valid", out_valid, 1);
    #2;
    rst = 1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_data", out_data, 0);
    tick();
    tick();
    rst = 0;
    tick();
    send_expect(32'h20401030, 32'h40302010, "post_rst");
    check("post_rst_busy", busy, 0);

    check("no_fifo_overflow", max_out <= 4, 1);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
